// File: rtl/register_file_nr_mw_if.sv
// Port bundle for the multi-port register file: read/write ports and the clear-engine handshake.
interface register_file_nr_mw_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 3,
    parameter int N_WRITE    = 2
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [N_READ-1:0][ADDR_WIDTH-1:0]  raddr_i;
    logic [N_READ-1:0][DATA_WIDTH-1:0]  rdata_o;
    logic [N_WRITE-1:0]                 we_i;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [N_WRITE-1:0][BE_WIDTH-1:0]   wbe_i;
    logic                               clear_req_i;
    logic                               clear_busy_o;
    logic                               clear_done_o;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, wbe_i, clear_req_i,
        input  rdata_o, clear_busy_o, clear_done_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, wbe_i, clear_req_i,
        output rdata_o, clear_busy_o, clear_done_o
    );
endinterface

// File: rtl/register_file_nr_mw.sv
// Multi-read/multi-write register file with byte enables and a sequential clear engine.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write bytes to the read ports.
module register_file_nr_mw #(
    parameter int                    ADDR_WIDTH  = 5,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    N_READ      = 3,
    parameter int                    N_WRITE     = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    register_file_nr_mw_if.slave  bus
);
    localparam int                    NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                    clear_busy;
    logic                    clear_done;

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_view;

    // ---------------- clear engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clear_req_i) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                // A request seen in the done cycle chains straight into another pass.
                if (cnt_reg == LAST_ADDR) begin
                    state_next = bus.clear_req_i ? CLEAR : IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign clear_busy       = (state_reg == CLEAR);
    assign clear_done       = clear_busy && (cnt_reg == LAST_ADDR);
    assign bus.clear_busy_o = clear_busy;
    assign bus.clear_done_o = clear_done;

    // ---------------- storage, one register per word ----------------
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        localparam logic [ADDR_WIDTH-1:0] WORD_ADDR = ADDR_WIDTH'(gi);

        logic [DATA_WIDTH-1:0] word_reg;
        logic [DATA_WIDTH-1:0] word_next;
        logic                  clear_hit;

        assign clear_hit = clear_busy && (cnt_reg == WORD_ADDR);

        // Later ports overwrite earlier ones, so the highest index wins per byte.
        always_comb begin
            word_next = word_reg;
            if (clear_hit) begin
                word_next = CLEAR_VALUE;
            end else begin
                for (int k = 0; k < N_WRITE; k++) begin
                    for (int b = 0; b < BE_WIDTH; b++) begin
                        if (bus.we_i[k] && (bus.waddr_i[k] == WORD_ADDR) && bus.wbe_i[k][b]) begin
                            word_next[8*b +: 8] = bus.wdata_i[k][8*b +: 8];
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else begin
                word_reg <= word_next;
            end
        end

        assign mem_view[gi] = word_reg;
    end

    // ---------------- read ports ----------------
    for (genvar gi = 0; gi < N_READ; gi++) begin : g_read
        logic [DATA_WIDTH-1:0] rd_word;

        always_comb begin
            rd_word = mem_view[bus.raddr_i[gi]];
`ifdef RF_WRITE_BYPASS_EN
            // Forward only bytes that will really land; the word under the clear cursor never does.
            for (int k = 0; k < N_WRITE; k++) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (bus.we_i[k] && bus.wbe_i[k][b] &&
                        (bus.waddr_i[k] == bus.raddr_i[gi]) &&
                        !(clear_busy && (bus.waddr_i[k] == cnt_reg))) begin
                        rd_word[8*b +: 8] = bus.wdata_i[k][8*b +: 8];
                    end
                end
            end
`else
            rd_word = rd_word;
`endif
        end

        assign bus.rdata_o[gi] = rst_n ? rd_word : '0;
    end

endmodule

// File: tb/tb_register_file_nr_mw.sv
// Self-checking bench: array/queue reference model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_register_file_nr_mw;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NR     = 3;
    localparam int NW     = 2;
    localparam int BW     = DW / 8;
    localparam int NWORDS = 1 << AW;
    localparam logic [DW-1:0] CV = 32'hA5A5_5A5A;
`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    register_file_nr_mw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) bus ();

    register_file_nr_mw #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW), .CLEAR_VALUE(CV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain word array plus "clear started, position = cycles since start".
    logic [DW-1:0] model_mem [NWORDS];
    bit            clr_active;
    int            clr_pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) model_mem[i] <= '0;
            clr_active <= 1'b0;
            clr_pos    <= 0;
        end else begin
            for (int k = 0; k < NW; k++)
                for (int b = 0; b < BW; b++)
                    if (bus.we_i[k] && bus.wbe_i[k][b] &&
                        !(clr_active && int'(bus.waddr_i[k]) == clr_pos))
                        model_mem[bus.waddr_i[k]][8*b +: 8] <= bus.wdata_i[k][8*b +: 8];
            if (clr_active) begin
                model_mem[clr_pos] <= CV;
                if (clr_pos == NWORDS - 1) begin
                    clr_active <= bus.clear_req_i;
                    clr_pos    <= 0;
                end else begin
                    clr_pos <= clr_pos + 1;
                end
            end else if (bus.clear_req_i) begin
                clr_active <= 1'b1;
                clr_pos    <= 0;
            end
        end
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = model_mem[a];
        if (BYP) begin
            for (int k = 0; k < NW; k++)
                for (int b = 0; b < BW; b++)
                    if (bus.we_i[k] && bus.wbe_i[k][b] && bus.waddr_i[k] == a &&
                        !(clr_active && int'(bus.waddr_i[k]) == clr_pos))
                        v[8*b +: 8] = bus.wdata_i[k][8*b +: 8];
        end
        return rst_n ? v : '0;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++)
            check($sformatf("model_rdata%0d", p), bus.rdata_o[p], model_read(bus.raddr_i[p]));
        check("model_busy", DW'(bus.clear_busy_o), DW'(clr_active));
        check("model_done", DW'(bus.clear_done_o), DW'(clr_active && clr_pos == NWORDS - 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we_i        = '0;
        bus.waddr_i     = '0;
        bus.wdata_i     = '0;
        bus.wbe_i       = '0;
        bus.clear_req_i = 1'b0;
    endtask

    initial begin
        int busy_n;
        int done_n;
        int done_at;

        idle_inputs();
        bus.raddr_i = '0;

        // Reset, then read 0/15/31.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.raddr_i[0] = 5'd0;
        bus.raddr_i[1] = 5'd15;
        bus.raddr_i[2] = 5'd31;
        @(negedge clk);
        for (int p = 0; p < NR; p++) check("reset_read", bus.rdata_o[p], 32'h0000_0000);
        check("reset_busy", DW'(bus.clear_busy_o), '0);
        tick();

        // Two ports hit addr 3 in one cycle; port 1 owns the low bytes.
        bus.we_i       = 2'b11;
        bus.waddr_i[0] = 5'd3;  bus.wdata_i[0] = 32'h1122_3344; bus.wbe_i[0] = 4'hF;
        bus.waddr_i[1] = 5'd3;  bus.wdata_i[1] = 32'hAABB_CCDD; bus.wbe_i[1] = 4'h3;
        tick();
        idle_inputs();
        bus.raddr_i[0] = 5'd3;
        @(negedge clk);
        check("arb_addr3", bus.rdata_o[0], 32'h1122_CCDD);
        tick();

        // Same-cycle read of a word being written.
        bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd7; bus.wdata_i[0] = 32'hCAFE_F00D; bus.wbe_i[0] = 4'hF;
        bus.raddr_i[1] = 5'd7;
        @(negedge clk);
        check("bypass_same_cycle", bus.rdata_o[1], BYP ? 32'hCAFE_F00D : 32'h0000_0000);
        tick();
        idle_inputs();
        @(negedge clk);
        check("bypass_next_cycle", bus.rdata_o[1], 32'hCAFE_F00D);
        tick();

        // Mixed directed traffic: partial byte enables, occasional port collisions.
        for (int i = 0; i < 24; i++) begin
            bus.we_i       = NW'(i % 4);
            bus.waddr_i[0] = AW'((i * 7) % NWORDS);
            bus.waddr_i[1] = AW'((i % 3 == 0) ? (i * 7) % NWORDS : (i * 7 + 5) % NWORDS);
            bus.wdata_i[0] = 32'h0101_0101 * i ^ 32'hDEAD_0000;
            bus.wdata_i[1] = 32'h1020_3040 + i;
            bus.wbe_i[0]   = BW'((i * 5) % 16);
            bus.wbe_i[1]   = BW'(15 - (i % 16));
            bus.raddr_i[0] = AW'(((i - 1) * 7) % NWORDS);
            bus.raddr_i[1] = AW'((i * 7) % NWORDS);
            bus.raddr_i[2] = AW'((i * 3) % NWORDS);
            tick();
        end
        idle_inputs();

        // Fill with ones, then one full clear pass.
        for (int i = 0; i < NWORDS / 2; i++) begin
            bus.we_i       = 2'b11;
            bus.waddr_i[0] = AW'(2 * i);     bus.wdata_i[0] = 32'hFFFF_FFFF; bus.wbe_i[0] = 4'hF;
            bus.waddr_i[1] = AW'(2 * i + 1); bus.wdata_i[1] = 32'hFFFF_FFFF; bus.wbe_i[1] = 4'hF;
            tick();
        end
        idle_inputs();
        bus.clear_req_i = 1'b1;
        tick();
        bus.clear_req_i = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.clear_busy_o) busy_n++;
            if (bus.clear_done_o) begin
                done_n++;
                done_at = c;
            end
            tick();
        end
        check("clear_busy_cycles", DW'(busy_n), 32'd32);
        check("clear_done_count", DW'(done_n), 32'd1);
        check("clear_done_cycle", DW'(done_at), 32'd31);
        for (int w = 0; w < NWORDS; w++) begin
            bus.raddr_i[2] = AW'(w);
            @(negedge clk);
            check($sformatf("cleared_word%0d", w), bus.rdata_o[2], CV);
            tick();
        end

        // Writes during a clear: below the cursor persists, at the cursor loses.
        bus.clear_req_i = 1'b1;
        tick();
        bus.clear_req_i = 1'b0;
        for (int c = 0; c < NWORDS; c++) begin
            bus.we_i = '0;
            if (c == 5) begin
                bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd2; bus.wdata_i[0] = 32'h5; bus.wbe_i[0] = 4'hF;
            end
            if (c == 9) begin
                bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd9; bus.wdata_i[0] = 32'h7; bus.wbe_i[0] = 4'hF;
            end
            bus.clear_req_i = (c == NWORDS - 1);
            @(negedge clk);
            check("clear2_busy", DW'(bus.clear_busy_o), 32'd1);
            check("clear2_done", DW'(bus.clear_done_o), DW'(c == NWORDS - 1));
            tick();
        end
        idle_inputs();

        // Request held in the done cycle: a new pass starts at cnt 0, words 2/9 not yet revisited.
        bus.raddr_i[0] = 5'd2;
        bus.raddr_i[1] = 5'd9;
        @(negedge clk);
        check("restart_busy", DW'(bus.clear_busy_o), 32'd1);
        check("cursor_below_kept", bus.rdata_o[0], 32'h0000_0005);
        check("cursor_hit_lost", bus.rdata_o[1], CV);
        tick();
        repeat (9) tick();

        // Reset at cnt 10 aborts the pass.
        check("pre_reset_busy", DW'(bus.clear_busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", DW'(bus.clear_busy_o), 32'd0);
        check("abort_done", DW'(bus.clear_done_o), 32'd0);
        check("abort_rdata", bus.rdata_o[0], 32'h0000_0000);
        tick();
        tick();
        rst_n = 1'b1;
        for (int w = 0; w < NWORDS; w++) begin
            bus.raddr_i[0] = AW'(w);
            @(negedge clk);
            check($sformatf("post_abort_word%0d", w), bus.rdata_o[0], 32'h0000_0000);
            check("post_abort_busy", DW'(bus.clear_busy_o), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 ns");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/register_file_nr_mw.md
REGISTER_FILE_NR_MW -- requirements
Module: register_file_nr_mw

Interface
REQ-001 The block SHALL provide parameter ADDR_WIDTH, default 5, word address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 32, word width, a multiple of 8.
REQ-003 The block SHALL provide parameter N_READ, default 3, number of read ports, minimum 1.
REQ-004 The block SHALL provide parameter N_WRITE, default 2, number of write ports, minimum 1.
REQ-005 The block SHALL provide parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written by the clear engine.
REQ-006 The block SHALL provide port clk, input, 1, clock; all state SHALL be updated on the rising edge.
REQ-007 The block SHALL provide port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 The block SHALL provide port raddr_i, input, N_READ x ADDR_WIDTH, read address per port.
REQ-009 The block SHALL provide port rdata_o, output, N_READ x DATA_WIDTH, read data per port.
REQ-010 The block SHALL provide port we_i, input, N_WRITE, write enable per port.
REQ-011 The block SHALL provide port waddr_i, input, N_WRITE x ADDR_WIDTH, write address per port.
REQ-012 The block SHALL provide port wdata_i, input, N_WRITE x DATA_WIDTH, write data per port.
REQ-013 The block SHALL provide port wbe_i, input, N_WRITE x DATA_WIDTH/8, byte enable per port.
REQ-014 The block SHALL provide port clear_req_i, input, 1, request to clear the whole array.
REQ-015 The block SHALL provide port clear_busy_o, output, 1, high while the clear engine is active.
REQ-016 The block SHALL provide port clear_done_o, output, 1, one-cycle pulse marking the cycle the last word is cleared.

Function
REQ-017 Reads SHALL be combinational: rdata_o[p] = array[raddr_i[p]], with zero-cycle latency.
REQ-018 Write behaviour SHALL be as follows:
- A write lands at the next rising edge.
- Byte b of word w is written when we_i[k], waddr_i[k]==w and wbe_i[k][b] all hold.
- Bytes with wbe_i low SHALL hold their value.
REQ-019 Byte-level write arbitration SHALL give priority to the highest-index write port; the other ports' conflicting bytes are dropped.
REQ-020 The clear engine SHALL be an FSM with states IDLE and CLEAR and an ADDR_WIDTH-bit counter cnt.
REQ-021 In IDLE, a sampled clear_req_i SHALL move the FSM to CLEAR with cnt=0.
REQ-022 In CLEAR, each cycle SHALL write CLEAR_VALUE to word cnt and then increment cnt.
REQ-023 When cnt==NUM_WORDS-1, the FSM SHALL write the last word and return to IDLE; a clear therefore takes exactly NUM_WORDS cycles.
REQ-024 clear_busy_o SHALL equal (state==CLEAR).
REQ-025 clear_done_o SHALL equal (state==CLEAR and cnt==NUM_WORDS-1).
REQ-026 clear_req_i SHALL be ignored while in CLEAR.
REQ-027 A clear_req_i held high in the done cycle SHALL start a new clear on the next edge.
REQ-028 User writes SHALL remain enabled during CLEAR, with these rules:
- In a given cycle, a write to word cnt loses entirely to the clear.
- Writes to words below cnt persist.
- Writes to words above cnt are later overwritten.

Reset
REQ-029 On assertion of rst_n low, all words SHALL go to 0 (not CLEAR_VALUE) immediately, FSM to IDLE, cnt to 0.
REQ-030 rdata_o SHALL read 0 during reset; clear_busy_o and clear_done_o SHALL be 0 during reset.
REQ-031 Reset asserted mid-clear SHALL abort the clear with no done pulse.

Configuration
REQ-032 Macro RF_WRITE_BYPASS_EN SHALL control write-to-read bypass.
REQ-033 With RF_WRITE_BYPASS_EN defined, the bypass SHALL behave as follows:
- A read whose address matches a same-cycle enabled write returns the arbitrated write bytes combinationally.
- Unwritten bytes come from the array.
- The clear engine is never bypassed.
- A write to word cnt during CLEAR is not bypassed.
REQ-034 Without RF_WRITE_BYPASS_EN, rdata_o SHALL reflect array contents only; new data is visible the cycle after the write edge.

Verification
REQ-035 Reset, then read addresses 0, 15, 31 -> all rdata_o = 0x00000000.
REQ-036 Port0 writes addr 3 = 0x11223344, wbe 0xF; port1 writes addr 3 = 0xAABBCCDD, wbe 0x3, same cycle -> next cycle addr 3 reads 0x1122CCDD.
REQ-037 Fill all words with 0xFFFFFFFF, pulse clear_req_i -> clear_busy_o high for 32 cycles; clear_done_o pulses only in the 32nd; afterwards all words read CLEAR_VALUE.
REQ-038 During a clear, write 0x5 to addr 2 when cnt==5, and 0x7 to addr 9 when cnt==9 -> after done, addr 2 reads 0x5 and addr 9 reads CLEAR_VALUE.
REQ-039 Assert rst_n low at cnt==10 -> busy drops immediately, no done pulse, all words 0.
REQ-040 With RF_WRITE_BYPASS_EN, write addr 7 = 0xCAFEF00D and read addr 7 in the same cycle -> rdata_o = 0xCAFEF00D that cycle; without the macro -> old value that cycle, new value next cycle.
